// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential signed multiplier: FSM state
// encoding and the default operand width.
package seq_mult_pkg;

    localparam int MULT_N = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2
    } state_t;

endpackage : seq_mult_pkg

// File: rtl/mult_step_counter.sv
// Up-counting step counter that sequences the N add/shift iterations.
// Synchronous clear wins over enable; the terminal flag marks the last step.
module mult_step_counter
    import seq_mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clr,
    input  logic                   i_en,
    output logic [$clog2(N)-1:0]   o_count,
    output logic                   o_terminal
);

    localparam int CW = $clog2(N);

    logic [CW-1:0] r_count;

    // Step count register: clear has priority, otherwise count when enabled.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_count    = r_count;
    assign o_terminal = (r_count == CW'(N - 1));

endmodule : mult_step_counter

// File: rtl/seq_signed_mult_core.sv
// Sequential sign-magnitude shift-and-add multiplier. Magnitudes of both
// operands are captured on start, N add/shift steps build the unsigned
// product, and a final cycle applies the sign. Fixed latency of N+1 clocks.
module seq_signed_mult_core
    import seq_mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [N-1:0]       i_multiplicand,
    input  logic [N-1:0]       i_multiplier,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*N-1:0]     o_product
);

    localparam int CW = $clog2(N);

    state_t           r_state;
    state_t           w_state_next;
    logic [2*N-1:0]   r_mcand;
    logic [2*N-1:0]   r_acc;
    logic [2*N-1:0]   r_product;
    logic [N-1:0]     r_mplr;
    logic             r_neg;
    logic             r_done;

    logic [N-1:0]     w_mag_a;
    logic [N-1:0]     w_mag_b;
    logic             w_busy;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic             w_last_step;
    logic [CW-1:0]    w_unused_count;

    // Magnitudes as N-bit unsigned values; the most negative input maps to
    // 2^(N-1), which still fits in N unsigned bits.
    assign w_mag_a = i_multiplicand[N-1] ? (~i_multiplicand + N'(1)) : i_multiplicand;
    assign w_mag_b = i_multiplier[N-1]   ? (~i_multiplier   + N'(1)) : i_multiplier;

    // Counter is held at zero whenever idle and only advances during CALC,
    // stopping at the terminal value so it never wraps on its own.
    assign w_cnt_clr = (r_state == ST_IDLE);
    assign w_cnt_en  = (r_state == ST_CALC) && !w_last_step;

    mult_step_counter #(
        .N (N)
    ) u_step_counter (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_cnt_clr),
        .i_en       (w_cnt_en),
        .o_count    (w_unused_count),
        .o_terminal (w_last_step)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and busy decode.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                w_busy = 1'b1;
                if (w_last_step) begin
                    w_state_next = ST_SIGN;
                end
            end
            ST_SIGN: begin
                w_busy       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, add/shift steps, sign fix-up and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_acc     <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_mcand <= {{N{1'b0}}, w_mag_a};
                        r_mplr  <= w_mag_b;
                        r_neg   <= i_multiplicand[N-1] ^ i_multiplier[N-1];
                        r_acc   <= '0;
                    end
                end
                ST_CALC: begin
                    if (r_mplr[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand <= r_mcand << 1;
                    r_mplr  <= r_mplr >> 1;
                end
                ST_SIGN: begin
                    // Negating a zero accumulator wraps back to zero, so a
                    // negative-signed zero product is still all zeros.
                    r_product <= r_neg ? (~r_acc + (2*N)'(1)) : r_acc;
                    r_done    <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy    = w_busy;
    assign o_done    = r_done;
    assign o_product = r_product;

endmodule : seq_signed_mult_core

// File: tb/tb_seq_signed_mult_core.sv
// Directed bench for seq_signed_mult_core at N=8, plus N=4 and N=16
// instances exercised with extremes and random operands against a signed
// reference multiply.
module tb_seq_signed_mult_core;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic               st4, st8, st16;
    logic signed [3:0]  a4, b4;
    logic signed [7:0]  a8, b8;
    logic signed [15:0] a16, b16;
    logic               bz4, bz8, bz16;
    logic               dn4, dn8, dn16;
    logic signed [7:0]  p4;
    logic signed [15:0] p8;
    logic signed [31:0] p16;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    seq_signed_mult_core #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .i_start(st4), .i_multiplicand(a4), .i_multiplier(b4),
        .o_busy(bz4), .o_done(dn4), .o_product(p4)
    );

    seq_signed_mult_core #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .i_start(st8), .i_multiplicand(a8), .i_multiplier(b8),
        .o_busy(bz8), .o_done(dn8), .o_product(p8)
    );

    seq_signed_mult_core #(.N(16)) dut16 (
        .clk(clk), .rst(rst), .i_start(st16), .i_multiplicand(a16), .i_multiplier(b16),
        .o_busy(bz16), .o_done(dn16), .o_product(p16)
    );

    function automatic logic get_done(input int w);
        case (w)
            4:       return dn4;
            16:      return dn16;
            default: return dn8;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            4:       return bz4;
            16:      return bz16;
            default: return bz8;
        endcase
    endfunction

    function automatic logic signed [31:0] get_prod(input int w);
        logic signed [31:0] r;
        case (w)
            4:       r = p4;
            16:      r = p16;
            default: r = p8;
        endcase
        return r;
    endfunction

    task automatic set_in(input int w, input logic signed [15:0] a, input logic signed [15:0] b,
                          input logic s);
        case (w)
            4:       begin a4 = a[3:0];  b4 = b[3:0];  st4 = s;  end
            16:      begin a16 = a;      b16 = b;      st16 = s; end
            default: begin a8 = a[7:0];  b8 = b[7:0];  st8 = s;  end
        endcase
    endtask

    task automatic set_start(input int w, input logic s);
        case (w)
            4:       st4 = s;
            16:      st16 = s;
            default: st8 = s;
        endcase
    endtask

    // Present operands with start; returns #1 after the sampling edge E0.
    task automatic start_op(input int w, input logic signed [15:0] a, input logic signed [15:0] b,
                            input bit hold);
        @(negedge clk);
        set_in(w, a, b, 1'b1);
        @(posedge clk);
        #1;
        if (!hold) set_start(w, 1'b0);
    endtask

    // Waits (bounded) for done; checks latency, product, busy, and pulse width.
    // With chain set, new operands and start are presented in the done cycle.
    task automatic wait_done(input int w, input logic signed [31:0] exp, input string name,
                             input bit chain, input logic signed [15:0] na,
                             input logic signed [15:0] nb);
        int cyc = 0;
        bit seen = 0;
        while (!seen && cyc < 40) begin
            if (get_done(w)) seen = 1;
            else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_mis++;
            $display("FAIL %s_timeout: no done within %0d cycles (N=%0d)", name, cyc, w);
        end else begin
            n_cmp++;
            if (cyc != w + 1) begin
                n_mis++;
                $display("FAIL %s_latency: got %0d cycles, want %0d", name, cyc, w + 1);
            end
            n_cmp++;
            if (get_prod(w) !== exp) begin
                n_mis++;
                $display("FAIL %s_product: got %0d, want %0d", name, get_prod(w), exp);
            end
            n_cmp++;
            if (get_busy(w) !== 1'b0) begin
                n_mis++;
                $display("FAIL %s_busy_in_done: got %b, want 0", name, get_busy(w));
            end
            if (chain) set_in(w, na, nb, 1'b1);
            @(posedge clk);
            #1;
            n_cmp++;
            if (get_done(w) !== 1'b0) begin
                n_mis++;
                $display("FAIL %s_done_width: done still %b one cycle later, want 0", name, get_done(w));
            end
        end
    endtask

    task automatic test_reset();
        int dcount = 0;
        #1;
        n_cmp++;
        if (bz8 !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b, want 0", bz8); end
        n_cmp++;
        if (dn8 !== 1'b0) begin n_mis++; $display("FAIL reset_done: got %b, want 0", dn8); end
        n_cmp++;
        if (p8 !== 16'sd0) begin n_mis++; $display("FAIL reset_product: got %0d, want 0", p8); end
        @(negedge clk);
        rst = 1'b0;

        start_op(8, 2, 2, 0);
        wait_done(8, 4, "pre_op", 0, 0, 0);

        // Abort 5*3 mid-CALC.
        start_op(8, 5, 3, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (p8 !== 16'sd0) begin n_mis++; $display("FAIL abort_product: got %0d, want 0", p8); end
        n_cmp++;
        if (bz8 !== 1'b0) begin n_mis++; $display("FAIL abort_busy: got %b, want 0", bz8); end
        n_cmp++;
        if (dn8 !== 1'b0) begin n_mis++; $display("FAIL abort_done: got %b, want 0", dn8); end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (dn8) dcount++;
        end
        n_cmp++;
        if (dcount != 0) begin n_mis++; $display("FAIL abort_no_done: got %0d pulses, want 0", dcount); end

        start_op(8, 5, 3, 0);
        wait_done(8, 15, "after_reset", 0, 0, 0);
    endtask

    task automatic test_signs();
        start_op(8, -7, 6, 0);
        wait_done(8, -42, "neg_pos", 0, 0, 0);
        start_op(8, 7, -6, 0);
        wait_done(8, -42, "pos_neg", 0, 0, 0);
        start_op(8, -7, -6, 0);
        wait_done(8, 42, "neg_neg", 0, 0, 0);
        n_cmp++;
        if (p8 !== 16'sd42) begin n_mis++; $display("FAIL hold_product: got %0d, want 42", p8); end
    endtask

    task automatic test_extremes();
        start_op(8, -128, -128, 0);
        wait_done(8, 16384, "min_min", 0, 0, 0);
        start_op(8, -128, 127, 0);
        wait_done(8, -16256, "min_max", 0, 0, 0);
        start_op(8, 127, 127, 0);
        wait_done(8, 16129, "max_max", 0, 0, 0);
        start_op(8, 0, -128, 0);
        wait_done(8, 0, "zero_neg", 0, 0, 0);
    endtask

    task automatic test_start_held();
        start_op(8, 3, 4, 1);
        a8 = 8'sd9;
        b8 = 8'sd9;
        wait_done(8, 12, "held_first", 0, 0, 0);
        n_cmp++;
        if (bz8 !== 1'b1) begin n_mis++; $display("FAIL held_restart_busy: got %b, want 1", bz8); end
        st8 = 1'b0;
        wait_done(8, 81, "held_second", 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        start_op(8, -3, 5, 0);
        wait_done(8, -15, "b2b_first", 1, 11, -2);
        n_cmp++;
        if (bz8 !== 1'b1) begin n_mis++; $display("FAIL b2b_busy: got %b, want 1", bz8); end
        st8 = 1'b0;
        wait_done(8, -22, "b2b_second", 0, 0, 0);
    endtask

    task automatic test_sweep(input int w);
        int lo = -(2 ** (w - 1));
        int hi = (2 ** (w - 1)) - 1;
        logic signed [15:0] a, b;
        logic signed [3:0]  t4a, t4b;
        int ea, eb;
        start_op(w, 16'(lo), 16'(lo), 0);
        wait_done(w, lo * lo, $sformatf("n%0d_min_min", w), 0, 0, 0);
        start_op(w, 16'(lo), 16'(hi), 0);
        wait_done(w, lo * hi, $sformatf("n%0d_min_max", w), 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            if (w == 4) begin
                t4a = 4'($urandom);
                t4b = 4'($urandom);
                a = t4a;
                b = t4b;
            end else begin
                a = 16'($urandom);
                b = 16'($urandom);
            end
            ea = a;
            eb = b;
            start_op(w, a, b, 0);
            wait_done(w, ea * eb, $sformatf("n%0d_rand%0d", w, i), 0, 0, 0);
        end
    endtask

    initial begin
        set_in(4, 0, 0, 1'b0);
        set_in(8, 0, 0, 1'b0);
        set_in(16, 0, 0, 1'b0);
        test_reset();
        test_signs();
        test_extremes();
        test_start_held();
        test_back_to_back();
        test_sweep(4);
        test_sweep(16);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_seq_signed_mult_core
